// File: rtl/md_pkg.sv
// md_pkg: shared multiply/divide op, HI/LO select and state encodings
package md_pkg;
   localparam logic [2:0] MD_MS    = 3'b000;
   localparam logic [2:0] MD_MU    = 3'b001;
   localparam logic [2:0] MD_DS    = 3'b010;
   localparam logic [2:0] MD_DU    = 3'b011;
   localparam logic [2:0] MD_MADD  = 3'b100;
   localparam logic [2:0] MD_MADDU = 3'b101;
   localparam logic [2:0] MD_MSUB  = 3'b110;
   localparam logic [2:0] MD_MSUBU = 3'b111;
   localparam logic [1:0] MD_HI = 2'b01;
   localparam logic [1:0] MD_LO = 2'b10;
   typedef enum logic {IDLE, RUN} md_state_t;
   function automatic logic is_div(input logic [2:0] op);
      return op[2:1] == 2'b01;
   endfunction
endpackage

// File: rtl/md_latency_counter.sv
// md_latency_counter: loadable down-counter flagging the last busy cycle
module md_latency_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] val,
   output logic         done
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk) begin
      if (!reset) cnt <= '0;
      else if (load) cnt <= val;
      else if (dec && !done) cnt <= cnt - W'(1);
   end
   assign done = cnt == '0;
endmodule

// File: rtl/md_unit.sv
// md_unit: parametrised multiply/divide unit with HI/LO registers and stall request
module md_unit
   import md_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       re,
   input  logic [1:0]       we,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             busy,
   output logic             stall
);
   localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC) + 1;
   md_state_t state, state_nx;
   logic load, commit, done, sdiv;
   logic [2:0] op_q;
   logic [WIDTH-1:0] a_q, b_q, hi, lo, ua, ub, uq, ur, q, r;
   logic [2*WIDTH-1:0] acc, prod_s, prod_u, prod, result;
   logic [CW-1:0] lat;

   always_ff @(posedge clk) state <= !reset ? IDLE : state_nx;
   always_comb state_nx = state == IDLE ? (start ? RUN : IDLE) : (done ? IDLE : RUN);
   always_comb begin
      busy   = state == RUN;
      load   = state == IDLE && start;
      commit = state == RUN && done;
      stall  = start || busy;
   end

   assign lat = is_div(op) ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
   md_latency_counter #(.W(CW)) u_cnt (
      .clk(clk), .reset(reset), .load(load), .dec(busy), .val(lat), .done(done)
   );

   always_ff @(posedge clk) if (load) {op_q, a_q, b_q} <= {op, a, b};

   // signed divide runs on magnitudes so MIN/-1 wraps to MIN with zero remainder
   assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
   assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
   assign prod   = op_q[0] ? prod_u : prod_s;
   assign acc    = {hi, lo};
   assign sdiv   = op_q == MD_DS;
   assign ua     = sdiv && a_q[WIDTH-1] ? -a_q : a_q;
   assign ub     = sdiv && b_q[WIDTH-1] ? -b_q : b_q;
   assign uq     = ub == '0 ? '0 : ua / ub;
   assign ur     = ub == '0 ? '0 : ua % ub;
   assign q      = sdiv && (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -uq : uq;
   assign r      = sdiv && a_q[WIDTH-1] ? -ur : ur;
   assign result = is_div(op_q) ? {r, q} : !op_q[2] ? prod : op_q[1] ? acc - prod : acc + prod;

   always_ff @(posedge clk) begin
      if (!reset) begin
         hi <= '0;
         lo <= '0;
      end else if (commit) begin
         if (!(is_div(op_q) && b_q == '0)) {hi, lo} <= result;
      end else if (state == IDLE && !start) begin
         if (we == MD_HI) hi <= wdata;
         if (we == MD_LO) lo <= wdata;
      end
   end

   assign rdata = re == MD_HI ? hi : re == MD_LO ? lo : '0;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit against an independent HI/LO model
module tb_md_unit;
   import md_pkg::*;
   logic clk = 0, reset = 0, start = 0, busy, stall;
   logic [2:0] op = '0;
   logic [31:0] a = '0, b = '0, wdata = '0, rdata;
   logic [1:0] re = '0, we = '0;
   logic [31:0] mhi = '0, mlo = '0;
   logic [63:0] sb[$];
   int tests = 0, fails = 0;

   md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .re(re),
      .we(we), .wdata(wdata), .rdata(rdata), .busy(busy), .stall(stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      int sx, sy;
      longint lx, ly, qq, rr;
      logic [63:0] acc, ps, pu;
      sx = x; sy = y; lx = sx; ly = sy;
      acc = {mhi, mlo};
      ps = lx * ly;
      pu = {32'b0, x} * {32'b0, y};
      case (o)
         MD_MS:    return ps;
         MD_MU:    return pu;
         MD_DS: begin
            if (y == 0) return acc;
            qq = lx / ly; rr = lx % ly;
            return {rr[31:0], qq[31:0]};
         end
         MD_DU:    return y == 0 ? acc : {x % y, x / y};
         MD_MADD:  return acc + ps;
         MD_MADDU: return acc + pu;
         MD_MSUB:  return acc - ps;
         default:  return acc - pu;
      endcase
   endfunction

   task automatic read_hl(output logic [63:0] v);
      re = MD_HI; #1 v[63:32] = rdata;
      re = MD_LO; #1 v[31:0] = rdata;
   endtask

   task automatic wait_done(input int n);
      int c = 0;
      logic [63:0] exp, got;
      re = MD_LO;
      #1;
      while (busy && c < 200) begin
         c++;
         check("rdata_busy", {32'b0, rdata}, {32'b0, mlo});
         @(negedge clk); #1;
      end
      check("latency", c, n);
      exp = sb.pop_front();
      read_hl(got);
      check("hilo", got, exp);
      {mhi, mlo} = exp;
   endtask

   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      start = 1; op = o; a = x; b = y;
      #1 check("stall_start", {63'b0, stall}, 64'd1);
      sb.push_back(model(o, x, y));
      @(negedge clk);
      start = 0;
      wait_done(is_div(o) ? 10 : 5);
   endtask

   task automatic write_reg(input logic [1:0] sel, input logic [31:0] d);
      logic [63:0] got;
      @(negedge clk);
      we = sel; wdata = d;
      @(negedge clk);
      we = '0;
      if (sel == MD_HI) mhi = d; else mlo = d;
      read_hl(got);
      check("mtx", got, {mhi, mlo});
   endtask

   initial begin
      logic [63:0] v;
      logic [2:0] o;
      logic [31:0] x, y;
      repeat (2) @(negedge clk);
      reset = 1;
      re = MD_HI; #1 check("rst_hi", {32'b0, rdata}, 64'd0);
      re = MD_LO; #1 check("rst_lo", {32'b0, rdata}, 64'd0);
      check("rst_busy", {63'b0, busy}, 64'd0);
      check("rst_stall", {63'b0, stall}, 64'd0);
      re = '0; #1 check("rst_none", {32'b0, rdata}, 64'd0);

      run_op(MD_MS, -32'sd3, 32'd7);
      read_hl(v); check("mult_const", v, 64'hFFFFFFFF_FFFFFFEB);
      write_reg(MD_HI, 32'd0);
      write_reg(MD_LO, 32'd10);
      run_op(MD_MADD, 32'd4, 32'd5);
      read_hl(v); check("madd_const", v, 64'd30);
      run_op(MD_MSUBU, 32'd2, 32'd20);
      read_hl(v); check("msubu_const", v, 64'hFFFFFFFF_FFFFFFF6);
      run_op(MD_DS, -32'sd7, 32'd2);
      read_hl(v); check("div_const", v, 64'hFFFFFFFF_FFFFFFFD);
      run_op(MD_DS, 32'd55, 32'd0);
      read_hl(v); check("div0_const", v, 64'hFFFFFFFF_FFFFFFFD);
      run_op(MD_DS, 32'h80000000, 32'hFFFFFFFF);
      read_hl(v); check("minneg1_const", v, 64'h00000000_80000000);

      // start with a simultaneous mthi, then a stray start while busy
      write_reg(MD_HI, 32'd1);
      @(negedge clk);
      start = 1; op = MD_MADD; a = 32'd6; b = 32'd7; we = MD_HI; wdata = 32'hDEAD;
      sb.push_back(model(MD_MADD, 32'd6, 32'd7));
      @(negedge clk); start = 0; we = '0;
      @(negedge clk);
      @(negedge clk); start = 1; op = MD_DU; a = 32'd100; b = 32'd3;
      #1 check("stall_busy", {63'b0, stall}, 64'd1);
      @(negedge clk); start = 0;
      wait_done(2);
      repeat (12) @(negedge clk);
      #1 check("no_restart", {63'b0, busy}, 64'd0);
      read_hl(v); check("single_commit", v, {mhi, mlo});
      read_hl(v); check("madd_dropwr", v, 64'h00000001_80000000 + 64'd42);

      for (int i = 0; i < 8; i++) begin
         o = 3'($urandom_range(0, 7));
         x = $urandom;
         y = (is_div(o) && $urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         run_op(o, x, y);
      end

      // reset in the third busy cycle of a divu
      write_reg(MD_LO, 32'd5);
      @(negedge clk);
      start = 1; op = MD_DU; a = 32'd99; b = 32'd4;
      @(negedge clk); start = 0;
      @(negedge clk);
      @(negedge clk); reset = 0;
      @(negedge clk); reset = 1;
      #1 check("rst_mid_busy", {63'b0, busy}, 64'd0);
      read_hl(v); check("rst_mid_hilo", v, 64'd0);
      repeat (15) @(negedge clk);
      read_hl(v); check("rst_no_commit", v, 64'd0);
      #1 check("rst_idle", {63'b0, busy}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
